// File: rtl/adc_sampler_ctrl.sv
// Multi-channel ADC front-end: registered ADC_CLK from a TIME_BASE-selected
// phase counter, per-period capture, optional peak/average decimation, 1-deep output register.
module adc_sampler_ctrl #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int TB_W     = 6,
  parameter int TB_MAX   = 17,
  parameter int DEC_LOG2 = 1
) (
  input  logic                     CLK_64MHZ,
  input  logic                     MASTER_RST,
  input  logic                     ENABLE,
  input  logic [TB_W-1:0]          TIME_BASE,
  input  logic [1:0]               MODE,
  input  logic [NUM_CH*DATA_W-1:0] ADC_DATA,
  output logic                     ADC_CLK,
  output logic                     SAMP_VALID,
  input  logic                     SAMP_READY,
  output logic [NUM_CH*DATA_W-1:0] SAMP_DATA,
  output logic [NUM_CH*DATA_W-1:0] SAMP_MAX,
  output logic                     OVERRUN
);

  localparam int PH_W  = TB_MAX + 1;
  localparam int ACC_W = DATA_W + DEC_LOG2;
  localparam int DW    = NUM_CH * DATA_W;

  localparam logic [1:0]          MODE_PEAK = 2'b01;
  localparam logic [1:0]          MODE_AVG  = 2'b10;
  localparam logic [TB_W-1:0]     TB_LIMIT  = TB_W'(TB_MAX);
  localparam logic [DEC_LOG2-1:0] GRP_LAST  = '1;

  logic [TB_W-1:0]     r_tb;
  logic [1:0]          r_mode;
  logic                r_en;
  logic [PH_W-1:0]     r_phase;
  logic [DEC_LOG2-1:0] r_grp;
  logic                r_adc_clk;
  logic [DATA_W-1:0]   r_min [NUM_CH];
  logic [DATA_W-1:0]   r_max [NUM_CH];
  logic [ACC_W-1:0]    r_acc [NUM_CH];

  logic                r_valid;
  logic                r_overrun;
  logic [DW-1:0]       r_data;
  logic [DW-1:0]       r_data_max;

  logic                w_idle;
  logic                w_restart;
  logic [PH_W-1:0]     w_half;
  logic [PH_W-1:0]     w_last_ph;
  logic [PH_W-1:0]     w_phase_next;
  logic                w_strobe;
  logic                w_grouped;
  logic                w_grp_first;
  logic                w_result;
  logic [DATA_W-1:0]   w_smp    [NUM_CH];
  logic [DATA_W-1:0]   w_min_nx [NUM_CH];
  logic [DATA_W-1:0]   w_max_nx [NUM_CH];
  logic [ACC_W-1:0]    w_acc_nx [NUM_CH];
  logic [DW-1:0]       w_res_data;
  logic [DW-1:0]       w_res_max;

  // Restart is detected against the registered copies, so the cycle after any
  // change (or ENABLE rising) always begins at phase 0 of the new rate.
  assign w_idle       = !ENABLE || (TIME_BASE >= TB_LIMIT);
  assign w_restart    = (TIME_BASE != r_tb) || (MODE != r_mode) || !r_en;
  assign w_half       = PH_W'(1) << TIME_BASE;
  assign w_last_ph    = (w_half << 1) - PH_W'(1);
  assign w_phase_next = (r_phase == w_last_ph) ? '0 : r_phase + PH_W'(1);
  assign w_strobe     = !w_idle && !w_restart && (r_phase == w_last_ph);
  assign w_grouped    = (r_mode == MODE_PEAK) || (r_mode == MODE_AVG);
  assign w_grp_first  = (r_grp == '0);
  assign w_result     = w_strobe && (!w_grouped || (r_grp == GRP_LAST));

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    w_res_data = '0;
    w_res_max  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_smp[ch]    = ADC_DATA[ch*DATA_W +: DATA_W];
      w_min_nx[ch] = (w_grp_first || (w_smp[ch] < r_min[ch])) ? w_smp[ch] : r_min[ch];
      w_max_nx[ch] = (w_grp_first || (w_smp[ch] > r_max[ch])) ? w_smp[ch] : r_max[ch];
      w_acc_nx[ch] = (w_grp_first ? '0 : r_acc[ch]) + ACC_W'(w_smp[ch]);
      case (r_mode)
        MODE_PEAK: begin
          w_res_data[ch*DATA_W +: DATA_W] = w_min_nx[ch];
          w_res_max[ch*DATA_W +: DATA_W]  = w_max_nx[ch];
        end
        MODE_AVG: begin
          w_res_data[ch*DATA_W +: DATA_W] = w_acc_nx[ch][ACC_W-1:DEC_LOG2];
          w_res_max[ch*DATA_W +: DATA_W]  = w_acc_nx[ch][ACC_W-1:DEC_LOG2];
        end
        default: begin
          w_res_data[ch*DATA_W +: DATA_W] = w_smp[ch];
          w_res_max[ch*DATA_W +: DATA_W]  = w_smp[ch];
        end
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_64MHZ) begin
    if (MASTER_RST) begin
      r_tb      <= '0;
      r_mode    <= '0;
      r_en      <= 1'b0;
      r_phase   <= '0;
      r_grp     <= '0;
      r_adc_clk <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_min[ch] <= '0;
        r_max[ch] <= '0;
        r_acc[ch] <= '0;
      end
    end else begin
      r_tb   <= TIME_BASE;
      r_mode <= MODE;
      r_en   <= ENABLE;
      if (w_idle) begin
        r_phase   <= '0;
        r_grp     <= '0;
        r_adc_clk <= 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          r_min[ch] <= '0;
          r_max[ch] <= '0;
          r_acc[ch] <= '0;
        end
      end else if (w_restart) begin
        r_phase   <= '0;
        r_grp     <= '0;
        r_adc_clk <= 1'b1;
      end else begin
        r_phase   <= w_phase_next;
        r_adc_clk <= (w_phase_next < w_half);
        if (w_strobe && w_grouped) begin
          r_grp <= r_grp + DEC_LOG2'(1);
          for (int ch = 0; ch < NUM_CH; ch++) begin
            r_min[ch] <= w_min_nx[ch];
            r_max[ch] <= w_max_nx[ch];
            r_acc[ch] <= w_acc_nx[ch];
          end
        end
      end
    end
  end

  // Single-entry output register; a result arriving while one is held un-accepted is dropped.
  always_ff @(posedge CLK_64MHZ) begin
    if (MASTER_RST) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_data_max <= '0;
      r_overrun  <= 1'b0;
    end else if (w_result) begin
      if (!r_valid || SAMP_READY) begin
        r_valid    <= 1'b1;
        r_data     <= w_res_data;
        r_data_max <= w_res_max;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && SAMP_READY) begin
      r_valid <= 1'b0;
    end
  end

  assign ADC_CLK    = r_adc_clk;
  assign SAMP_VALID = r_valid;
  assign SAMP_DATA  = r_data;
  assign SAMP_MAX   = r_data_max;
  assign OVERRUN    = r_overrun;

endmodule

// File: tb/tb_adc_sampler_ctrl.sv
// Bench for adc_sampler_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a cycle-count/sample-queue reference model.
module tb_adc_sampler_ctrl;

  localparam int DATA_W   = 8;
  localparam int NUM_CH   = 2;
  localparam int TB_W     = 6;
  localparam int TB_MAX   = 17;
  localparam int DEC_LOG2 = 1;
  localparam int DW       = NUM_CH * DATA_W;
  localparam int GRP      = 1 << DEC_LOG2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [TB_W-1:0] tb_sel;
  logic [1:0]      mode;
  logic [DW-1:0]   adc_data;
  logic            ready;
  logic            adc_clk;
  logic            samp_valid;
  logic [DW-1:0]   samp_data;
  logic [DW-1:0]   samp_max;
  logic            overrun;

  adc_sampler_ctrl #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .TB_W(TB_W), .TB_MAX(TB_MAX), .DEC_LOG2(DEC_LOG2)
  ) dut (
    .CLK_64MHZ (clk),
    .MASTER_RST(rst),
    .ENABLE    (en),
    .TIME_BASE (tb_sel),
    .MODE      (mode),
    .ADC_DATA  (adc_data),
    .ADC_CLK   (adc_clk),
    .SAMP_VALID(samp_valid),
    .SAMP_READY(ready),
    .SAMP_DATA (samp_data),
    .SAMP_MAX  (samp_max),
    .OVERRUN   (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles elapsed since the last restart, plus the samples of the open group.
  logic            m_prev_en;
  logic [TB_W-1:0] m_prev_tb;
  logic [1:0]      m_prev_mode;
  int              m_cnt;
  logic [DW-1:0]   m_q[$];
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [DW-1:0]   m_max;
  logic            m_ovr;
  logic            m_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic group_result(input logic [1:0] md, output logic [DW-1:0] lo, output logic [DW-1:0] hi);
    lo = '0;
    hi = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int mn, mx, sum;
      mn = 255; mx = 0; sum = 0;
      foreach (m_q[i]) begin
        logic [DW-1:0] word;
        int v;
        word = m_q[i];
        v = int'(word[ch*DATA_W +: DATA_W]);
        if (v < mn) mn = v;
        if (v > mx) mx = v;
        sum += v;
      end
      if (md == 2'b01) begin
        lo[ch*DATA_W +: DATA_W] = DATA_W'(mn);
        hi[ch*DATA_W +: DATA_W] = DATA_W'(mx);
      end else begin
        lo[ch*DATA_W +: DATA_W] = DATA_W'(sum / GRP);
        hi[ch*DATA_W +: DATA_W] = DATA_W'(sum / GRP);
      end
    end
  endtask

  task automatic model_edge();
    bit            idle, restart, new_res;
    int            p;
    logic [DW-1:0] lo, hi;
    new_res = 0;
    lo = '0;
    hi = '0;
    if (rst) begin
      m_prev_en = 0; m_prev_tb = '0; m_prev_mode = '0; m_cnt = 0; m_q.delete();
      m_valid = 0; m_data = '0; m_max = '0; m_ovr = 0; m_clk = 0;
    end else begin
      idle    = !en || (int'(tb_sel) >= TB_MAX);
      restart = (tb_sel != m_prev_tb) || (mode != m_prev_mode) || !m_prev_en;
      if (idle) begin
        m_cnt = 0; m_q.delete(); m_clk = 0;
      end else if (restart) begin
        m_cnt = 0; m_q.delete(); m_clk = 1;
      end else begin
        p = 1 << (int'(tb_sel) + 1);
        if (m_cnt % p == p - 1) begin
          if (mode == 2'b01 || mode == 2'b10) begin
            m_q.push_back(adc_data);
            if (m_q.size() == GRP) begin
              new_res = 1;
              group_result(mode, lo, hi);
              m_q.delete();
            end
          end else begin
            new_res = 1; lo = adc_data; hi = adc_data;
          end
        end
        m_cnt++;
        m_clk = (m_cnt % p) < (p / 2);
      end
      m_prev_en = en; m_prev_tb = tb_sel; m_prev_mode = mode;
      if (new_res) begin
        if (!m_valid || ready) begin
          m_valid = 1; m_data = lo; m_max = hi;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("adc_clk", 32'(adc_clk), 32'(m_clk));
    check("samp_valid", 32'(samp_valid), 32'(m_valid));
    check("samp_data", 32'(samp_data), 32'(m_data));
    check("samp_max", 32'(samp_max), 32'(m_max));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n_hi, n_val, first;
    int tb_opts[6] = '{0, 1, 2, 3, 17, 40};
    rst = 1'b1; en = 1'b0; tb_sel = '0; mode = 2'b00; adc_data = '0; ready = 1'b0;

    // Reset values
    do_reset();
    check("rst_adc_clk", 32'(adc_clk), 32'd0);
    check("rst_valid", 32'(samp_valid), 32'd0);
    check("rst_data", 32'(samp_data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // TB=0, SAMPLE: period 2, one result every 2 cycles
    en = 1'b1; tb_sel = 6'd0; mode = 2'b00; ready = 1'b1; adc_data = 16'h3412;
    step();
    n_hi = 0; n_val = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_hi += int'(adc_clk);
      n_val += int'(samp_valid);
    end
    check("tb0_clk_high", 32'(n_hi), 32'd4);
    check("tb0_valid_cnt", 32'(n_val), 32'd4);
    check("tb0_data", 32'(samp_data), 32'h3412);

    // TB=2: 4 high, 4 low, capture at phase 7
    tb_sel = 6'd2; adc_data = 16'h5566;
    step();
    n_hi = 0; n_val = 0; first = -1;
    for (int i = 1; i <= 16; i++) begin
      step();
      n_hi += int'(adc_clk);
      n_val += int'(samp_valid);
      if (samp_valid && first < 0) first = i;
    end
    check("tb2_clk_high", 32'(n_hi), 32'd8);
    check("tb2_valid_cnt", 32'(n_val), 32'd2);
    check("tb2_first_valid", 32'(first), 32'd8);

    // TB=17: out of range, clock parked low, no results
    tb_sel = 6'd17;
    n_hi = 0; n_val = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_hi += int'(adc_clk);
      n_val += int'(samp_valid);
    end
    check("tb17_clk_high", 32'(n_hi), 32'd0);
    check("tb17_valid_cnt", 32'(n_val), 32'd0);

    // PEAK: ch0 0x80,0x20 ch1 0x11,0x99
    do_reset();
    en = 1'b1; tb_sel = 6'd0; mode = 2'b01; ready = 1'b0;
    step();
    adc_data = 16'h1180; step(); step();
    check("peak_mid_valid", 32'(samp_valid), 32'd0);
    adc_data = 16'h9920; step(); step();
    check("peak_valid", 32'(samp_valid), 32'd1);
    check("peak_min", 32'(samp_data), 32'h1120);
    check("peak_max", 32'(samp_max), 32'h9980);

    // AVG: ch0 (0xFF+0x02)>>1=0x80, ch1 (0x10+0x20)>>1=0x18
    do_reset();
    en = 1'b1; tb_sel = 6'd0; mode = 2'b10; ready = 1'b0;
    step();
    adc_data = 16'h10FF; step(); step();
    adc_data = 16'h2002; step(); step();
    check("avg_data", 32'(samp_data), 32'h1880);
    check("avg_max", 32'(samp_max), 32'h1880);

    // Overrun while holding, then accept-and-load on the same edge
    do_reset();
    en = 1'b1; tb_sel = 6'd0; mode = 2'b00; ready = 1'b0;
    step();
    adc_data = 16'hAAAA; step(); step();
    check("ovr_first", 32'(samp_data), 32'hAAAA);
    adc_data = 16'hBBBB; step(); step();
    check("ovr_held", 32'(samp_data), 32'hAAAA);
    check("ovr_flag", 32'(overrun), 32'd1);
    adc_data = 16'hCCCC; step();
    ready = 1'b1; step();
    check("ovr_reload_valid", 32'(samp_valid), 32'd1);
    check("ovr_reload_data", 32'(samp_data), 32'hCCCC);
    step();
    check("ovr_drain_valid", 32'(samp_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // TIME_BASE change mid-group in PEAK, then reset mid-period
    do_reset();
    en = 1'b1; tb_sel = 6'd1; mode = 2'b01; ready = 1'b1;
    step();
    adc_data = 16'h0101; for (int i = 0; i < 4; i++) step();
    tb_sel = 6'd2; step();
    adc_data = 16'h0202;
    n_val = 0;
    for (int i = 0; i < 8; i++) begin step(); n_val += int'(samp_valid); end
    check("discard_no_result", 32'(n_val), 32'd0);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1; step();
    check("midrst_valid", 32'(samp_valid), 32'd0);
    check("midrst_clk", 32'(adc_clk), 32'd0);
    check("midrst_data", 32'(samp_data), 32'd0);
    rst = 1'b0; mode = 2'b00; adc_data = 16'h7788;
    step();
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (samp_valid && first < 0) first = i;
    end
    check("post_rst_first", 32'(first), 32'd8);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      adc_data = DW'($urandom);
      ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) tb_sel = TB_W'(tb_opts[$urandom_range(0, 5)]);
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 199) == 0) en = ~en;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
